dm_port_arbiter: RTL
====================

// Module: dm_port_arbiter
// PURPOSE
//  Shares the single MMU data-memory port (dm_addr/dm_di/dm_we/dm_be/is_signed -> dm_do) between
//  two masters: the core load/store stage (port C) and the DMA/debug loader (port D).
//  Grants one request per cycle, tracks the MMU's one-clock read latency, routes dm_do back
//  to the owner. C has priority; a starvation counter forces a D grant after a bounded C streak.
// PARAMETERS
//  STARVE_LIMIT  4  consecutive C grants with D pending before D is forced (legal range 1..255)
//  CNT_W         8  width of starvation counter; must hold STARVE_LIMIT
// PORTS
//  clk           in   1   clock
//  resetb        in   1   asynchronous, active-low reset
//  c_req         in   1   C request valid
//  c_we          in   1   C write enable
//  c_addr        in   32  C byte address
//  c_wdata       in   32  C write data (LSB-aligned, MMU shifts)
//  c_be          in   4   C byte enable (MMU encoding: 1111/1100/0011/0001/0010/0100/1000)
//  c_signed      in   1   C sign-extend load
//  c_gnt         out  1   C request accepted this cycle (combinational)
//  c_rvalid      out  1   C response valid (read data or write ack)
//  d_req, d_we, d_addr, d_wdata, d_be, d_signed, d_gnt, d_rvalid: as C, for port D
//  rdata         out  32  response data = mmu_dm_do, qualified by c_rvalid/d_rvalid
//  mmu_dm_addr   out  32  to MMU dm_addr
//  mmu_dm_di     out  32  to MMU dm_di
//  mmu_dm_we     out  1   to MMU dm_we
//  mmu_dm_be     out  4   to MMU dm_be
//  mmu_signed    out  1   to MMU is_signed
//  mmu_dm_do     in   32  from MMU dm_do
// BEHAVIOUR
//  - Transfer on a port = req && gnt in the same cycle; gnt is combinational from req + state.
//  - Grant: only C req -> C; only D req -> D; both -> C unless starve_cnt == STARVE_LIMIT, then D.
//  - At most one gnt high per cycle; no req -> no gnt.
//  - MMU outputs are combinational mux of granted port's fields. No grant: mmu_dm_we=0,
//    mmu_dm_be=4'b0000, mmu_dm_addr=0, mmu_dm_di=0, mmu_signed=0.
//  - starve_cnt (CNT_W bits): +1 when C granted while d_req high; cleared when D granted or
//    d_req low; saturates at STARVE_LIMIT, never wraps.
//  - Response: registered owner resp_sel[1:0] (00 none, 01 C, 10 D) captured on every
//    transfer; next cycle c_rvalid = resp_sel[0], d_rvalid = resp_sel[1], rdata = mmu_dm_do.
//  - Latency: exactly 1 cycle req/gnt -> rvalid; throughput one transfer per cycle, back-to-back
//    transfers of either port allowed, alternation needs no bubble.
//  - rvalid asserted for writes too (ack); rdata unspecified on write responses.
//  - Request fields must be held stable while req high and gnt low; arbiter has no buffering.
//  - Reset (async, any time): resp_sel=00 so c_rvalid=d_rvalid=0 immediately; starve_cnt=0;
//    in-flight response dropped; requesters must reissue. gnt/mmu_* follow inputs combinationally.
// TESTING
//  1. C only, read 0x10000004 be=1111, MMU returns 0x12345678 -> c_gnt same cycle, c_rvalid=1
//     next cycle with rdata=0x12345678; d_gnt, d_rvalid stay 0.
//  2. c_req,d_req held high 20 cycles, STARVE_LIMIT=4 -> grant order C,C,C,C,D repeating;
//     each rvalid one cycle after its grant.
//  3. D only, write 0x10000010 wdata=0x000000EF be=0001 -> mmu_dm_we=1, mmu_dm_be=0001,
//     mmu_dm_di=0x000000EF same cycle; d_rvalid=1 next cycle.
//  4. No requests -> mmu_dm_we=0, mmu_dm_be=0000, no rvalid following cycle.
//  5. D pending, after 3 C grants d_req drops one cycle then returns -> counter cleared; D
//     granted only after 4 further C grants.
//  6. resetb low the cycle after a C grant -> c_rvalid forced 0 at once; after release first
//     contended cycle grants C, starve_cnt counts from 0.

Source files
------------

// File: rtl/dm_port_arbiter.sv
// Two-master arbiter for the single MMU data-memory port: core load/store (C) has priority,
// DMA/debug loader (D) is forced through after a bounded C streak. One-cycle response routing.

package dm_port_arbiter_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned BE_W   = 4;

   // One data-memory access as presented to the MMU
   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [BE_W-1:0]   be;
      logic              is_signed;
   } dm_req_t;

   localparam dm_req_t DM_REQ_IDLE = '0;

endpackage

module dm_port_arbiter
   import dm_port_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned CNT_W        = 8
) (
   input  logic              clk,
   input  logic              resetb,

   input  logic              c_req,
   input  logic              c_we,
   input  logic [ADDR_W-1:0] c_addr,
   input  logic [DATA_W-1:0] c_wdata,
   input  logic [BE_W-1:0]   c_be,
   input  logic              c_signed,
   output logic              c_gnt,
   output logic              c_rvalid,

   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   input  logic [BE_W-1:0]   d_be,
   input  logic              d_signed,
   output logic              d_gnt,
   output logic              d_rvalid,

   output logic [DATA_W-1:0] rdata,

   output logic [ADDR_W-1:0] mmu_dm_addr,
   output logic [DATA_W-1:0] mmu_dm_di,
   output logic              mmu_dm_we,
   output logic [BE_W-1:0]   mmu_dm_be,
   output logic              mmu_signed,
   input  logic [DATA_W-1:0] mmu_dm_do
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
   localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

   dm_req_t          c_fields;
   dm_req_t          d_fields;
   dm_req_t          mmu_req;
   logic [CNT_W-1:0] starve_cnt;
   logic [CNT_W-1:0] starve_nxt;
   logic [1:0]       resp_sel;
   logic [1:0]       resp_nxt;

   assign c_fields = '{we: c_we, addr: c_addr, wdata: c_wdata, be: c_be, is_signed: c_signed};
   assign d_fields = '{we: d_we, addr: d_addr, wdata: d_wdata, be: d_be, is_signed: d_signed};

   // Grant: C wins contention unless D has waited STARVE_LIMIT C grants
   always_comb begin
      c_gnt = 1'b0;
      d_gnt = 1'b0;
      if (c_req && d_req) begin
         if (starve_cnt == LIMIT) begin
            d_gnt = 1'b1;
         end else begin
            c_gnt = 1'b1;
         end
      end else begin
         c_gnt = c_req;
         d_gnt = d_req;
      end
   end

   // MMU request mux; idle fields when nobody is granted
   always_comb begin
      mmu_req = DM_REQ_IDLE;
      if (c_gnt) begin
         mmu_req = c_fields;
      end else if (d_gnt) begin
         mmu_req = d_fields;
      end
   end

   assign mmu_dm_we   = mmu_req.we;
   assign mmu_dm_addr = mmu_req.addr;
   assign mmu_dm_di   = mmu_req.wdata;
   assign mmu_dm_be   = mmu_req.be;
   assign mmu_signed  = mmu_req.is_signed;

   // Starvation counter: counts C grants while D waits, saturating at the limit
   always_comb begin
      starve_nxt = starve_cnt;
      if (!d_req || d_gnt) begin
         starve_nxt = '0;
      end else if (c_gnt && (starve_cnt < LIMIT)) begin
         starve_nxt = starve_cnt + ONE;
      end
   end

   assign resp_nxt = {d_req && d_gnt, c_req && c_gnt};

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         starve_cnt <= '0;
         resp_sel   <= 2'b00;
      end else begin
         starve_cnt <= starve_nxt;
         resp_sel   <= resp_nxt;
      end
   end

   // Response owner is the previous cycle's transfer; MMU read data passes straight through
   assign c_rvalid = resp_sel[0];
   assign d_rvalid = resp_sel[1];
   assign rdata    = mmu_dm_do;

endmodule
